// File: rtl/shift_chain.sv
// -----------------------------------------------------------------------------
// shift_chain
//
// Bidirectional shift register of DEPTH stages. Each stage holds WIDTH bits of
// data and a valid flag. The chain can shift forward (toward the tail), shift
// backward (toward the head), load all stages at once, or hold.
//
// Optional feature macro: SHIFT_CHAIN_ROTATE_EN
//   When defined, the input i_rotate is added. On a shift with i_rotate=1, the
//   stage falling off the end wraps into the entry stage. When the macro is
//   undefined, the chain behaves as if i_rotate were tied to 0.
//
// Parameters
//   WIDTH  bits per stage (>= 1)
//   DEPTH  number of stages (>= 2)
//
// Ports
//   i_clock      rising-edge clock
//   i_reset_n    asynchronous active-low reset; clears data, valid flags and fill
//   i_enable     0 holds all state, whatever the mode
//   i_mode       00 hold, 01 shift forward, 10 shift backward, 11 parallel load
//   i_data_in    serial word entering stage 0 (forward) or stage DEPTH-1 (backward)
//   i_valid      valid flag travelling with i_data_in
//   i_load_data  parallel load value, stage 0 in bits [WIDTH-1:0]
//   i_tap_sel    stage index presented on o_tap
//   i_rotate     (SHIFT_CHAIN_ROTATE_EN only) wrap the discarded stage around
//   o_head       stage 0 data
//   o_tail       stage DEPTH-1 data
//   o_tap        data of stage i_tap_sel, zero when the index is out of range
//   o_parallel   all stage data, packed as i_load_data
//   o_fill       registered count of valid stages
//   o_full       registered flag, o_fill == DEPTH
// -----------------------------------------------------------------------------
module shift_chain #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int TAP_W  = (DEPTH > 2) ? $clog2(DEPTH) : 1,
  localparam int FILL_W = $clog2(DEPTH + 1)
) (
  input  logic                     i_clock,
  input  logic                     i_reset_n,
  input  logic                     i_enable,
  input  logic [1:0]               i_mode,
  input  logic [WIDTH-1:0]         i_data_in,
  input  logic                     i_valid,
  input  logic [WIDTH*DEPTH-1:0]   i_load_data,
  input  logic [TAP_W-1:0]         i_tap_sel,
`ifdef SHIFT_CHAIN_ROTATE_EN
  input  logic                     i_rotate,
`endif
  output logic [WIDTH-1:0]         o_head,
  output logic [WIDTH-1:0]         o_tail,
  output logic [WIDTH-1:0]         o_tap,
  output logic [WIDTH*DEPTH-1:0]   o_parallel,
  output logic [FILL_W-1:0]        o_fill,
  output logic                     o_full
);

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_FWD  = 2'b01;
  localparam logic [1:0] MODE_BWD  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  logic [DEPTH-1:0][WIDTH-1:0] stage_data;
  logic [DEPTH-1:0][WIDTH-1:0] data_next;
  logic [DEPTH-1:0]            stage_vld;
  logic [DEPTH-1:0]            vld_next;
  logic [FILL_W-1:0]           fill_q;
  logic [FILL_W-1:0]           fill_next;
  logic                        full_q;
  logic                        rotate;

`ifdef SHIFT_CHAIN_ROTATE_EN
  assign rotate = i_rotate;
`else
  assign rotate = 1'b0;
`endif

  // Population count of the valid flags. Because the fill is recomputed from
  // the flags rather than tracked with increments, it cannot wrap and always
  // agrees with the stages, including the rotate case.
  function automatic logic [FILL_W-1:0] count_valid(input logic [DEPTH-1:0] v);
    logic [FILL_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt = cnt + FILL_W'(v[i]);
    end
    return cnt;
  endfunction

  always_comb begin
    data_next = stage_data;
    vld_next  = stage_vld;
    if (i_enable) begin
      case (i_mode)
        MODE_FWD: begin
          for (int i = 1; i < DEPTH; i++) begin
            data_next[i] = stage_data[i-1];
            vld_next[i]  = stage_vld[i-1];
          end
          data_next[0] = rotate ? stage_data[DEPTH-1] : i_data_in;
          vld_next[0]  = rotate ? stage_vld[DEPTH-1]  : i_valid;
        end
        MODE_BWD: begin
          for (int i = 0; i < DEPTH - 1; i++) begin
            data_next[i] = stage_data[i+1];
            vld_next[i]  = stage_vld[i+1];
          end
          data_next[DEPTH-1] = rotate ? stage_data[0] : i_data_in;
          vld_next[DEPTH-1]  = rotate ? stage_vld[0]  : i_valid;
        end
        MODE_LOAD: begin
          data_next = i_load_data;
          vld_next  = '1;
        end
        MODE_HOLD: begin
        end
        default: begin
        end
      endcase
    end
  end

  assign fill_next = count_valid(vld_next);

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      stage_data <= '0;
      stage_vld  <= '0;
      fill_q     <= '0;
      full_q     <= 1'b0;
    end else begin
      stage_data <= data_next;
      stage_vld  <= vld_next;
      fill_q     <= fill_next;
      full_q     <= (fill_next == FILL_W'(DEPTH));
    end
  end

  // Tap select: a compare per stage keeps an out-of-range index from ever
  // addressing past the array; no match leaves the output at zero.
  always_comb begin
    o_tap = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i_tap_sel == TAP_W'(i)) begin
        o_tap = stage_data[i];
      end
    end
  end

  assign o_head     = stage_data[0];
  assign o_tail     = stage_data[DEPTH-1];
  assign o_parallel = stage_data;
  assign o_fill     = fill_q;
  assign o_full     = full_q;

endmodule

// File: tb/tb_shift_chain.sv
module tb_shift_chain;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic                   clk;
  logic                   rst_n;
  logic                   enable;
  logic [1:0]             mode;
  logic [WIDTH-1:0]       data_in;
  logic                   valid;
  logic [WIDTH*DEPTH-1:0] load_data;
  logic [1:0]             tap_sel;
`ifdef SHIFT_CHAIN_ROTATE_EN
  logic                   rotate;
`endif
  logic [WIDTH-1:0]       head;
  logic [WIDTH-1:0]       tail;
  logic [WIDTH-1:0]       tap;
  logic [WIDTH*DEPTH-1:0] parallel;
  logic [2:0]             fill;
  logic                   full;

  int n_vec = 0;
  int n_err = 0;

  shift_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .i_clock     (clk),
    .i_reset_n   (rst_n),
    .i_enable    (enable),
    .i_mode      (mode),
    .i_data_in   (data_in),
    .i_valid     (valid),
    .i_load_data (load_data),
    .i_tap_sel   (tap_sel),
`ifdef SHIFT_CHAIN_ROTATE_EN
    .i_rotate    (rotate),
`endif
    .o_head      (head),
    .o_tail      (tail),
    .o_tap       (tap),
    .o_parallel  (parallel),
    .o_fill      (fill),
    .o_full      (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] actual,
                           input logic [63:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Advance one active edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fwd(input logic [7:0] d, input logic v);
    enable = 1'b1; mode = 2'b01; data_in = d; valid = v;
    step();
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; mode = 2'b00; data_in = '0; valid = 1'b0;
    load_data = '0; tap_sel = '0;
`ifdef SHIFT_CHAIN_ROTATE_EN
    rotate = 1'b0;
`endif
    #2;
    check_val("reset_parallel", parallel, 0);
    check_val("reset_fill", fill, 0);
    check_val("reset_full", full, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill: tail reaches the first word on the 4th forward edge
    fwd(8'hA1, 1'b1);
    check_val("fill1_head", head, 8'hA1);
    check_val("fill1_fill", fill, 1);
    check_val("fill1_full", full, 0);
    fwd(8'hB2, 1'b1);
    fwd(8'hC3, 1'b1);
    check_val("fill3_tail", tail, 8'h00);
    check_val("fill3_fill", fill, 3);
    fwd(8'hD4, 1'b1);
    check_val("fill4_tail", tail, 8'hA1);
    check_val("fill4_head", head, 8'hD4);
    check_val("fill4_parallel", parallel, 32'hA1B2C3D4);
    check_val("fill4_fill", fill, 4);
    check_val("fill4_full", full, 1);

    // Enable low overrides shift mode
    enable = 1'b0; mode = 2'b01; data_in = 8'h99; valid = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check_val("disabled_parallel", parallel, 32'hA1B2C3D4);
    check_val("disabled_fill", fill, 4);

    // Drain with invalid words
    fwd(8'hEE, 1'b0);
    check_val("drain1_parallel", parallel, 32'hB2C3D4EE);
    check_val("drain1_fill", fill, 3);
    check_val("drain1_full", full, 0);
    fwd(8'h00, 1'b0);
    check_val("drain2_fill", fill, 2);

    // Hold mode with enable high
    enable = 1'b1; mode = 2'b00; data_in = 8'h12; valid = 1'b1;
    step();
    check_val("hold_parallel", parallel, 32'hC3D4EE00);
    check_val("hold_fill", fill, 2);

    // Parallel load and tap
    mode = 2'b11; load_data = 32'h44332211;
    step();
    check_val("load_parallel", parallel, 32'h44332211);
    check_val("load_fill", fill, 4);
    check_val("load_full", full, 1);
    mode = 2'b00; tap_sel = 2'd2;
    #1;
    check_val("tap2", tap, 8'h33);
    tap_sel = 2'd0;
    #1;
    check_val("tap0", tap, 8'h11);
    tap_sel = 2'd3;
    #1;
    check_val("tap3", tap, 8'h44);

    // Backward shifts
    mode = 2'b10; data_in = 8'h55; valid = 1'b1;
    step();
    check_val("bwd1_parallel", parallel, 32'h55443322);
    check_val("bwd1_head", head, 8'h22);
    check_val("bwd1_fill", fill, 4);
    data_in = 8'h66; valid = 1'b0;
    step();
    check_val("bwd2_parallel", parallel, 32'h66554433);
    check_val("bwd2_fill", fill, 3);
    check_val("bwd2_full", full, 0);

    // Asynchronous reset between edges
    mode = 2'b11; load_data = 32'h44332211;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async_parallel", parallel, 0);
    check_val("async_fill", fill, 0);
    check_val("async_full", full, 0);
    step();
    check_val("rst_dominates", parallel, 0);
    #2;
    rst_n = 1'b1;
    fwd(8'h77, 1'b1);
    check_val("post_rst_head", head, 8'h77);
    check_val("post_rst_fill", fill, 1);

`ifdef SHIFT_CHAIN_ROTATE_EN
    begin
      logic [31:0] exp_rot [4];
      exp_rot[0] = 32'h33221144; exp_rot[1] = 32'h22114433;
      exp_rot[2] = 32'h11443322; exp_rot[3] = 32'h44332211;
      enable = 1'b1; mode = 2'b11; load_data = 32'h44332211;
      step();
      rotate = 1'b1; data_in = 8'hFF; valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
        fwd(8'hFF, 1'b0);
        check_val("rot_parallel", parallel, exp_rot[i]);
        check_val("rot_fill", fill, 4);
      end
      rotate = 1'b0;
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
